// File: rtl/tinyqv_mem_pkg.sv
// Shared encodings and helpers for the TinyQV nibble-serial memory responder.
package tinyqv_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [3:0] BASE_DEFAULT = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte lanes touched by a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      MEM_BYTE: m = 4'b0001 << off;
      MEM_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default:  m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicates the low store bits so every enabled lane sees the right data.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] word);
    logic [31:0] d;
    case (size)
      MEM_BYTE: d = {4{word[7:0]}};
      MEM_HALF: d = {2{word[15:0]}};
      default:  d = word;
    endcase
    return d;
  endfunction

  // Moves the addressed byte/half down to bit 0; upper bits keep whatever follows.
  function automatic logic [31:0] load_align(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] d;
    case (size)
      MEM_BYTE: d = word >> {off, 3'b000};
      MEM_HALF: d = word >> {off[1], 4'b0000};
      default:  d = word;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tinyqv_mem_bank.sv
// Small word register bank: byte-lane writes, asynchronous read, word 0 exported live.
module tinyqv_mem_bank #(
  parameter int NUM_WORDS = 4,
  parameter int WORD_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3:0]           i_lane_we,
  input  logic [WORD_BITS-1:0] i_wr_idx,
  input  logic [31:0]          i_wr_data,
  input  logic [WORD_BITS-1:0] i_rd_idx,
  output logic [31:0]          o_rd_data,
  output logic [31:0]          o_word0
);

  logic [31:0] r_mem [NUM_WORDS];

  // Bank storage: cleared on reset, each enabled byte lane written on the store clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_lane_we[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_word0   = r_mem[0];

endmodule

// File: rtl/tinyqv_mem_responder.sv
// Memory-side responder for the TinyQV nibble-serial load/store interface.
module tinyqv_mem_responder
  import tinyqv_mem_pkg::*;
#(
  parameter int         NUM_WORDS    = 4,
  parameter int         WORD_BITS    = 2,
  parameter logic [3:0] BASE         = BASE_DEFAULT,
  parameter int         WAIT_WINDOWS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  counter,
  input  logic [27:0] addr_in,
  input  logic        addr_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [3:0]  store_nibble,
  output logic [3:0]  load_nibble,
  output logic        load_ready,
  output logic        busy,
  output logic [31:0] word0
);

  localparam logic [1:0] WCNT_INIT = (WAIT_WINDOWS > 0) ? 2'(WAIT_WINDOWS - 1) : 2'd0;

  logic [31:0]          r_sh;
  logic [31:0]          r_rdata;
  logic [1:0]           r_wcnt;
  state_t               r_state;
  state_t               w_next_state;
  logic [1:0]           w_next_wcnt;
  logic                 w_load_accept;
  logic                 w_load_req;
  logic                 w_hit;
  logic [WORD_BITS-1:0] w_idx;
  logic [1:0]           w_off;
  logic [1:0]           w_size;
  logic [3:0]           w_lane_we;
  logic [31:0]          w_store_word;
  logic [31:0]          w_wr_data;
  logic [31:0]          w_rd_word;
  logic [31:0]          w_load_word;
  logic                 w_unused;

  // The signedness bit only matters to the core's extension logic.
  assign w_unused = mem_op[2];

  assign w_store_word = {store_nibble, r_sh[31:4]};
  assign w_hit        = (addr_in[27:24] == BASE) && (addr_in[23:WORD_BITS+2] == '0);
  assign w_idx        = addr_in[WORD_BITS+1:2];
  assign w_off        = addr_in[1:0];
  assign w_size       = mem_op[1:0];
  assign w_lane_we    = (addr_valid && is_store && w_hit) ? lane_mask(w_size, w_off) : 4'b0000;
  assign w_wr_data    = store_lanes(w_size, w_store_word);
  assign w_load_word  = w_hit ? load_align(w_size, w_off, w_rd_word) : '0;
  assign w_load_req   = addr_valid && is_load && (counter == 3'd7);

  tinyqv_mem_bank #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_BITS (WORD_BITS)
  ) u_bank (
    .clk       (clk),
    .rstn      (rstn),
    .i_lane_we (w_lane_we),
    .i_wr_idx  (w_idx),
    .i_wr_data (w_wr_data),
    .i_rd_idx  (w_idx),
    .o_rd_data (w_rd_word),
    .o_word0   (word0)
  );

  // Store shifter: collects the nibble stream so the full word is ready at counter 7.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sh <= '0;
    else       r_sh <= w_store_word;
  end

  // Load FSM registers; load data is captured already aligned at address time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 2'd0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_wcnt  <= w_next_wcnt;
      if (w_load_accept) r_rdata <= w_load_word;
    end
  end

  // Next-state logic; the last RESP clock may accept the next load back-to-back.
  always_comb begin
    w_next_state  = r_state;
    w_next_wcnt   = r_wcnt;
    w_load_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load_req) w_load_accept = 1'b1;
      end
      ST_WAIT: begin
        if (counter == 3'd7) begin
          if (r_wcnt == 2'd0) w_next_state = ST_RESP;
          else                w_next_wcnt  = r_wcnt - 2'd1;
        end
      end
      ST_RESP: begin
        if (counter == 3'd7) begin
          w_next_state = ST_IDLE;
          if (w_load_req) w_load_accept = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_load_accept) begin
      w_next_state = (WAIT_WINDOWS == 0) ? ST_RESP : ST_WAIT;
      w_next_wcnt  = WCNT_INIT;
    end
  end

  assign load_ready  = (r_state == ST_RESP);
  assign busy        = (r_state != ST_IDLE);
  assign load_nibble = load_ready ? r_rdata[{counter, 2'b00} +: 4] : 4'h0;

endmodule
